// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package display_pkg;

    localparam int N_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_sevenseg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 8-digit seven-segment scan with per-slot blanking and
// frame-aligned shadow update of the displayed value.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_en,
    output logic [2:0]  digit_sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    // slot_cnt_q/dig_q name the position the next edge presents; the
    // output registers then hold exactly that position's values.
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [2:0]    sel_q, sel_d;
    scan_state_t   state_q, state_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;
    logic [31:0]   pending_q, pending_d;
    logic [31:0]   active_q, active_d;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;

    assign nibble = active_q[{dig_q, 2'b00} +: 4];

    hex_to_sevenseg u_hex (
        .nibble_i (nibble),
        .seg_n_o  (hex_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + CW'(1);
        dig_d      = (slot_cnt_q == SLOT_LAST) ? dig_q + 3'd1 : dig_q;
        sel_d      = dig_q;
        seg_d      = SEG_BLANK;
        dp_d       = 1'b1;
        fd_d       = (slot_cnt_q == SLOT_LAST) && (dig_q == 3'(N_DIGITS - 1));
        pending_d  = load ? value : pending_q;
        // The newest load wins at the frame boundary, so active follows pending_d.
        active_d   = fd_q ? pending_d : active_q;

        case (state_q)
            BLANK:   if (slot_cnt_q == BLANK_END) state_d = SHOW;
            SHOW:    if (slot_cnt_q == '0) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        if (state_d == SHOW && digit_en[dig_q]) begin
            seg_d = hex_seg;
            dp_d  = ~dp_en[dig_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt_q <= '0;
            dig_q      <= '0;
            sel_q      <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
            pending_q  <= '0;
            active_q   <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_q      <= dig_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
        end
    end

    assign digit_sel  = sel_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with D=8, B=2: directed sequences, a
// hex-map vector table and randomized traffic against a cycle-level model.
module tb_display_scan_controller;

    localparam int D = 8;
    localparam int B = 2;
    localparam int FRAME = 8 * D;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] value;
    logic        load;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic [2:0]  digit_sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan_controller #(
        .REFRESH_DIV  (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .dp_en      (dp_en),
        .digit_sel  (digit_sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index since reset release plus the two data words.
    int          m_n = -1;
    logic [31:0] m_pend = '0;
    logic [31:0] m_act = '0;

    typedef struct {
        logic [31:0] val;
        logic [6:0]  exp_seg0;
        logic [6:0]  exp_seg7;
    } hex_vec_t;

    hex_vec_t vecs[6];

    function automatic logic [6:0] hexmap(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, m_n);
        end
    endtask

    // One clock edge with the currently driven inputs; model and DUT compared after it.
    task automatic step();
        int p, s, in_slot;
        logic lit;
        logic [6:0] e_seg;
        logic [2:0] e_sel;
        logic e_dp, e_fd;
        @(posedge clk);
        if (!reset_n) begin
            m_n    = -1;
            m_pend = '0;
            m_act  = '0;
            e_sel  = 3'd0;
            e_seg  = 7'h7F;
            e_dp   = 1'b1;
            e_fd   = 1'b0;
        end else begin
            m_n++;
            if (load) m_pend = value;
            if (m_n > 0 && m_n % FRAME == 0) m_act = m_pend;
            p       = m_n % FRAME;
            s       = p / D;
            in_slot = p % D;
            lit     = (in_slot >= B) && digit_en[s];
            e_sel   = 3'(s);
            e_seg   = lit ? hexmap(m_act[4*s +: 4]) : 7'h7F;
            e_dp    = lit ? ~dp_en[s] : 1'b1;
            e_fd    = (p == FRAME - 1);
        end
        #1;
        check("model_digit_sel", 32'(digit_sel), 32'(e_sel));
        check("model_seg_n", 32'(seg_n), 32'(e_seg));
        check("model_dp_n", 32'(dp_n), 32'(e_dp));
        check("model_frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic pulse_load(input logic [31:0] v);
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
    endtask

    // Advance at least one edge until the frame position equals pos.
    task automatic run_to(input int pos);
        step();
        for (int i = 0; i < 2 * FRAME && (m_n % FRAME) != pos; i++) step();
    endtask

    initial begin
        vecs[0] = '{32'hFEDC_BA98, 7'h00, 7'h0E};
        vecs[1] = '{32'h7654_3210, 7'h40, 7'h78};
        vecs[2] = '{32'h89AB_CDEF, 7'h0E, 7'h00};
        vecs[3] = '{32'h3000_0001, 7'h79, 7'h30};
        vecs[4] = '{32'hC000_000D, 7'h21, 7'h46};
        vecs[5] = '{32'h5000_0006, 7'h02, 7'h12};

        reset_n  = 1'b0;
        value    = '0;
        load     = 1'b0;
        digit_en = 8'hFF;
        dp_en    = 8'h00;
        repeat (3) step();
        check("reset_seg", 32'(seg_n), 32'h7F);
        check("reset_sel", 32'(digit_sel), 32'h0);
        check("reset_dp", 32'(dp_n), 32'h1);
        check("reset_fd", 32'(frame_done), 32'h0);

        // Reset release: blank/lit pattern, digit stepping and frame pulse.
        reset_n = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            step();
            if (i < 2) check("rel_blank", 32'(seg_n), 32'h7F);
            else if (i < 8) check("rel_lit0", 32'(seg_n), 32'h40);
            if (i == 8) check("rel_sel1", 32'(digit_sel), 32'h1);
            if (i == FRAME) check("rel_sel_wrap", 32'(digit_sel), 32'h0);
            check("rel_fd", 32'(frame_done), 32'(i == FRAME - 1));
        end

        // Hex map vectors: load, then check slots 0 and 7 of the following frame.
        for (int v = 0; v < 6; v++) begin
            pulse_load(vecs[v].val);
            run_to(FRAME - 1);
            run_to(2);
            check("hex_slot0", 32'(seg_n), 32'(vecs[v].exp_seg0));
            run_to(7 * D + 2);
            check("hex_slot7", 32'(seg_n), 32'(vecs[v].exp_seg7));
        end

        // Tear-free update: mid-frame load stays hidden until the next frame.
        pulse_load(32'h0);
        run_to(FRAME - 1);
        run_to(3 * D + 2);
        pulse_load(32'h1111_1111);
        for (int s = 4; s < 8; s++) begin
            run_to(s * D + 2);
            check("tear_old", 32'(seg_n), 32'h40);
        end
        run_to(2);
        check("tear_new", 32'(seg_n), 32'h79);

        // Load on the frame_done cycle goes straight to the next frame.
        run_to(FRAME - 1);
        check("bound_fd", 32'(frame_done), 32'h1);
        load  = 1'b1;
        value = 32'h2222_2222;
        step();
        load  = 1'b0;
        run_to(2);
        check("bound_new", 32'(seg_n), 32'h24);

        // Digit masking and decimal point.
        digit_en = 8'b1111_1110;
        dp_en    = 8'b0000_0010;
        run_to(FRAME - 1);
        for (int i = 0; i < 2 * D; i++) begin
            step();
            if (i < D + B) begin
                check("mask_seg", 32'(seg_n), 32'h7F);
                check("mask_dp", 32'(dp_n), 32'h1);
            end else begin
                check("dp_seg", 32'(seg_n), 32'h24);
                check("dp_on", 32'(dp_n), 32'h0);
            end
        end
        digit_en = 8'hFF;
        dp_en    = 8'h00;

        // Mid-slot reset discards both active and pending data.
        run_to(FRAME - 1);
        run_to(4);
        pulse_load(32'h3333_3333);
        run_to(5 * D + 3);
        reset_n = 1'b0;
        step();
        check("mrst_sel", 32'(digit_sel), 32'h0);
        check("mrst_seg", 32'(seg_n), 32'h7F);
        reset_n = 1'b1;
        run_to(2);
        check("mrst_active", 32'(seg_n), 32'h40);
        run_to(FRAME - 1);
        run_to(2);
        check("mrst_pending", 32'(seg_n), 32'h40);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n  = ($urandom_range(0, 399) != 0);
            load     = ($urandom_range(0, 15) == 0);
            value    = $urandom;
            if ($urandom_range(0, 31) == 0) digit_en = 8'($urandom);
            dp_en    = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
